// File: rtl/foo_pkg.sv
// foo_pkg: shared constants for the foo_ctrl frame-tracking slice.
// FSM encoding, Bayer pattern codes and default widths.
package foo_pkg;

  localparam int FOO_K_BIT        = 14;
  localparam int FOO_CH_NUM_BIT   = 2;
  localparam int FOO_GAIN_BIT     = 10;
  localparam int FOO_LINE_CNT_BIT = 13;
  localparam int FOO_ERR_CNT_BIT  = 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef logic [1:0] bayer_t;

  localparam bayer_t BAYER_RGGB = 2'd0;
  localparam bayer_t BAYER_GRBG = 2'd1;
  localparam bayer_t BAYER_GBRG = 2'd2;
  localparam bayer_t BAYER_BGGR = 2'd3;

endpackage

// File: rtl/foo_ctrl_if.sv
// foo_ctrl_if: input pixel stream (valid/ready) into foo_ctrl.
// master = pixel source, slave = foo_ctrl.
interface foo_ctrl_if
  import foo_pkg::*;
#(
  parameter int p_k_bit      = FOO_K_BIT,
  parameter int p_ch_num_bit = FOO_CH_NUM_BIT
) ();

  logic                            i_VALID;
  logic                            o_READY;
  logic [p_k_bit*p_ch_num_bit-1:0] i_PIXELS;
  logic                            i_SOF;
  logic                            i_EOL;

  modport master (
    output i_VALID,
    output i_PIXELS,
    output i_SOF,
    output i_EOL,
    input  o_READY
  );

  modport slave (
    input  i_VALID,
    input  i_PIXELS,
    input  i_SOF,
    input  i_EOL,
    output o_READY
  );

endinterface

// File: rtl/foo_ctrl_fsm.sv
// foo_ctrl_fsm: frame/line tracking, per-frame register shadows, error pulse.
// Error counter present only when FOO_CTRL_ERR_CNT_EN is defined.
module foo_ctrl_fsm
  import foo_pkg::*;
#(
  parameter int p_foo_gain_bit = FOO_GAIN_BIT,
  parameter int p_line_cnt_bit = FOO_LINE_CNT_BIT
) (
  input  logic                        i_CLK,
  input  logic                        i_RSTn,
  input  logic                        i_acc,
  input  logic                        i_sof,
  input  logic                        i_eol,
  input  bayer_t                      i_arr,
  input  logic [3*p_foo_gain_bit-1:0] i_gain,
  input  logic [p_line_cnt_bit-1:0]   i_height,
  input  logic                        i_err_clr,
  output logic                        o_keep,
  output logic                        o_y_lsb,
  output bayer_t                      o_arr,
  output logic [3*p_foo_gain_bit-1:0] o_coeff,
  output logic                        o_err,
  output logic [FOO_ERR_CNT_BIT-1:0]  o_err_cnt
);

  logic [0:0]                  state_q, state_d;
  logic [p_line_cnt_bit-1:0]   line_q, line_d, cur_line;
  logic                        par_q, par_d;
  bayer_t                      arr_q, arr_d;
  logic [3*p_foo_gain_bit-1:0] gain_q, gain_d;
  logic                        err_d;
  logic                        last;
  logic                        active;

  assign active = (state_q == ST_ACTIVE);

  // A SOF beat sees the live registers; later beats see the shadows.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    par_d    = par_q;
    arr_d    = arr_q;
    gain_d   = gain_q;
    err_d    = 1'b0;
    cur_line = i_sof ? '0 : line_q;
    last     = (i_height == '0) ||
               (cur_line == i_height - 1'b1);
    o_keep   = i_sof | active;
    o_y_lsb  = i_sof ? 1'b0 : par_q;
    o_arr    = i_sof ? i_arr : arr_q;
    o_coeff  = i_sof ? i_gain : gain_q;
    if (i_acc) begin
      unique case (1'b1)
        i_sof: begin
          err_d   = active;
          state_d = ST_ACTIVE;
          line_d  = '0;
          par_d   = 1'b0;
          arr_d   = i_arr;
          gain_d  = i_gain;
        end
        (!i_sof && !active): err_d = 1'b1;
        default: ;
      endcase
      if (o_keep && i_eol) begin
        line_d = cur_line + 1'b1;
        par_d  = ~o_y_lsb;
        if (last) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      par_q   <= 1'b0;
      arr_q   <= '0;
      gain_q  <= '0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      par_q   <= par_d;
      arr_q   <= arr_d;
      gain_q  <= gain_d;
      o_err   <= err_d;
    end
  end

`ifdef FOO_CTRL_ERR_CNT_EN
  logic [FOO_ERR_CNT_BIT-1:0] cnt_q;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      cnt_q <= '0;
    end else if (i_err_clr) begin
      cnt_q <= '0;
    end else if (o_err && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_err_cnt = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_err_cnt      = '0;
`endif

endmodule

// File: rtl/foo_ctrl.sv
// foo_ctrl: control/valid pipeline in front of the Bayer correction stage.
// Optional error counter: define FOO_CTRL_ERR_CNT_EN.
module foo_ctrl
  import foo_pkg::*;
#(
  parameter int p_k_bit        = FOO_K_BIT,
  parameter int p_ch_num_bit   = FOO_CH_NUM_BIT,
  parameter int p_foo_gain_bit = FOO_GAIN_BIT,
  parameter int p_line_cnt_bit = FOO_LINE_CNT_BIT
) (
  input  logic                            i_CLK,
  input  logic                            i_RSTn,
  foo_ctrl_if.slave                       s_in,
  input  logic [1:0]                      i_REG_FOO_ARR_TYPE,
  input  logic [3*p_foo_gain_bit-1:0]     i_REG_FOO_GAIN_VEC,
  input  logic [p_line_cnt_bit-1:0]       i_REG_FOO_HEIGHT,
  output logic [p_k_bit*p_ch_num_bit-1:0] o_PIXELS,
  output logic [1:0]                      o_ARR_TYPE,
  output logic                            o_Y_LSB,
  output logic [3*p_foo_gain_bit-1:0]     o_COEFF_VEC,
  output logic [1:0]                      o_ENA_VEC,
  output logic                            o_OUT_VALID,
  input  logic                            i_OUT_READY,
  output logic                            o_OUT_SOF,
  output logic                            o_OUT_EOL,
  output logic                            o_ERR,
  output logic [7:0]                      o_ERR_CNT,
  input  logic                            i_ERR_CLR
);

  logic                        stall;
  logic                        acc;
  logic                        keep;
  logic                        y_lsb;
  bayer_t                      arr;
  logic [3*p_foo_gain_bit-1:0] coeff;
  logic                        v0, v1, v2;
  logic                        sof0, sof1, sof2;
  logic                        eol0, eol1, eol2;

  assign stall       = v2 & ~i_OUT_READY;
  assign s_in.o_READY = ~stall;
  assign acc         = s_in.i_VALID & ~stall;
  // Correction stage is held frozen while reset is asserted.
  assign o_ENA_VEC   = {2{~stall & i_RSTn}};

  foo_ctrl_fsm #(
    .p_foo_gain_bit (p_foo_gain_bit),
    .p_line_cnt_bit (p_line_cnt_bit)
  ) u_fsm (
    .i_CLK     (i_CLK),
    .i_RSTn    (i_RSTn),
    .i_acc     (acc),
    .i_sof     (s_in.i_SOF),
    .i_eol     (s_in.i_EOL),
    .i_arr     (i_REG_FOO_ARR_TYPE),
    .i_gain    (i_REG_FOO_GAIN_VEC),
    .i_height  (i_REG_FOO_HEIGHT),
    .i_err_clr (i_ERR_CLR),
    .o_keep    (keep),
    .o_y_lsb   (y_lsb),
    .o_arr     (arr),
    .o_coeff   (coeff),
    .o_err     (o_ERR),
    .o_err_cnt (o_ERR_CNT)
  );

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_PIXELS    <= '0;
      o_Y_LSB     <= 1'b0;
      o_ARR_TYPE  <= '0;
      o_COEFF_VEC <= '0;
      v0   <= 1'b0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      sof0 <= 1'b0;
      sof1 <= 1'b0;
      sof2 <= 1'b0;
      eol0 <= 1'b0;
      eol1 <= 1'b0;
      eol2 <= 1'b0;
    end else if (!stall) begin
      o_PIXELS    <= s_in.i_PIXELS;
      o_Y_LSB     <= y_lsb;
      o_ARR_TYPE  <= arr;
      o_COEFF_VEC <= coeff;
      v0   <= acc & keep;
      sof0 <= acc & keep & s_in.i_SOF;
      eol0 <= acc & keep & s_in.i_EOL;
      v1   <= v0;
      sof1 <= sof0;
      eol1 <= eol0;
      v2   <= v1;
      sof2 <= sof1;
      eol2 <= eol1;
    end
  end

  assign o_OUT_VALID = v2;
  assign o_OUT_SOF   = sof2;
  assign o_OUT_EOL   = eol2;

endmodule

// File: tb/tb_foo_ctrl.sv
// tb_foo_ctrl: scoreboard bench for foo_ctrl (frame tracking, stall, errors).
// Honours FOO_CTRL_ERR_CNT_EN for the expected error count.
module tb_foo_ctrl;
  import foo_pkg::*;

  typedef struct {
    logic sof;
    logic eol;
    int   cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  reg_arr;
  logic [29:0] reg_gain;
  logic [12:0] reg_h;
  logic [27:0] o_pixels;
  logic [1:0]  o_arr_type;
  logic        o_y_lsb;
  logic [29:0] o_coeff_vec;
  logic [1:0]  o_ena_vec;
  logic        o_out_valid;
  logic        out_ready;
  logic        o_out_sof;
  logic        o_out_eol;
  logic        o_err;
  logic [7:0]  o_err_cnt;
  logic        err_clr;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   lat_on = 0;
  bit   rnd_rdy = 0;
  exp_t q[$];

  bit          m_active;
  int          m_line;
  bit          m_par;
  logic [1:0]  m_arr;
  logic [29:0] m_gain;
  bit          ev0, ev1, ev2;
  bit          exp_err;
  int          m_cnt;
  logic [27:0] pix_m;

  foo_ctrl_if #(.p_k_bit(14), .p_ch_num_bit(2)) in_if ();

  foo_ctrl dut (
    .i_CLK              (clk),
    .i_RSTn             (rst_n),
    .s_in               (in_if),
    .i_REG_FOO_ARR_TYPE (reg_arr),
    .i_REG_FOO_GAIN_VEC (reg_gain),
    .i_REG_FOO_HEIGHT   (reg_h),
    .o_PIXELS           (o_pixels),
    .o_ARR_TYPE         (o_arr_type),
    .o_Y_LSB            (o_y_lsb),
    .o_COEFF_VEC        (o_coeff_vec),
    .o_ENA_VEC          (o_ena_vec),
    .o_OUT_VALID        (o_out_valid),
    .i_OUT_READY        (out_ready),
    .o_OUT_SOF          (o_out_sof),
    .o_OUT_EOL          (o_out_eol),
    .o_ERR              (o_err),
    .o_ERR_CNT          (o_err_cnt),
    .i_ERR_CLR          (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(output bit accd);
    bit          stall, acc, keep, err_n;
    bit          y;
    logic [1:0]  a;
    logic [29:0] c;
    exp_t        e;
    if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    stall = ev2 && !out_ready;
    chk("ready", in_if.o_READY, !stall);
    chk("ena", o_ena_vec, stall ? 2'b00 : 2'b11);
    chk("ovalid", o_out_valid, ev2);
    if (ev2 && out_ready) begin
      if (q.size() == 0) chk("unexp_beat", 1, 0);
      else begin
        e = q.pop_front();
        chk("osof", o_out_sof, e.sof);
        chk("oeol", o_out_eol, e.eol);
        if (lat_on) chk("latency", cyc - e.cyc, 3);
      end
    end
    acc = in_if.i_VALID && !stall;
    keep = 0; err_n = 0; y = 0; a = '0; c = '0;
    if (acc) begin
      if (in_if.i_SOF) begin
        err_n = m_active;
        keep = 1; m_active = 1;
        m_line = 0; m_par = 0;
        m_arr = reg_arr; m_gain = reg_gain;
      end else if (!m_active) err_n = 1;
      else keep = 1;
      if (keep) begin
        y = m_par; a = m_arr; c = m_gain;
        if (in_if.i_EOL) begin
          if (reg_h == 0 || m_line == int'(reg_h) - 1) m_active = 0;
          m_line++;
          m_par = !m_par;
        end
      end
    end
`ifdef FOO_CTRL_ERR_CNT_EN
    if (err_clr) m_cnt = 0;
    else if (exp_err && m_cnt != 255) m_cnt++;
`endif
    if (!stall) begin
      ev2 = ev1; ev1 = ev0; ev0 = acc && keep;
      pix_m = in_if.i_PIXELS;
    end
    if (acc && keep) q.push_back('{in_if.i_SOF, in_if.i_EOL, cyc});
    exp_err = err_n;
    @(posedge clk);
    #1;
    cyc++;
    chk("pixels", o_pixels, pix_m);
    chk("err", o_err, exp_err);
    chk("err_cnt", o_err_cnt, m_cnt);
    if (acc && keep) begin
      chk("y_lsb", o_y_lsb, y);
      chk("arr", o_arr_type, a);
      chk("coeff", o_coeff_vec, c);
    end
    accd = acc;
  endtask

  task automatic idle(int n);
    bit g;
    in_if.i_VALID = 0;
    for (int i = 0; i < n; i++) step(g);
  endtask

  task automatic send(logic [27:0] p, logic s, logic e);
    bit g;
    int n = 0;
    in_if.i_VALID  = 1;
    in_if.i_PIXELS = p;
    in_if.i_SOF    = s;
    in_if.i_EOL    = e;
    do begin
      step(g);
      n++;
    end while (!g && n < 50);
    if (!g) chk("accept_timeout", 0, 1);
    in_if.i_VALID = 0;
    in_if.i_SOF   = 0;
    in_if.i_EOL   = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_if.i_VALID = 0;
    in_if.i_SOF = 0;
    in_if.i_EOL = 0;
    #3;
    chk("rst_ready", in_if.o_READY, 1);
    chk("rst_ovalid", o_out_valid, 0);
    chk("rst_sof_eol", {o_out_sof, o_out_eol}, 0);
    chk("rst_pix", o_pixels, 0);
    chk("rst_coeff", {o_coeff_vec, o_arr_type, o_y_lsb}, 0);
    chk("rst_ena", o_ena_vec, 0);
    chk("rst_err", {o_err, o_err_cnt}, 0);
    q.delete();
    m_active = 0; m_line = 0; m_par = 0;
    m_arr = '0; m_gain = '0;
    ev0 = 0; ev1 = 0; ev2 = 0;
    exp_err = 0; m_cnt = 0; pix_m = '0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit g;
    rst_n = 0;
    reg_arr = BAYER_GRBG;
    reg_gain = {10'd100, 10'd200, 10'd300};
    reg_h = 13'd1;
    out_ready = 1;
    err_clr = 0;
    in_if.i_PIXELS = '0;
    do_reset();

    // single-line frame, latency
    lat_on = 1;
    send(28'h0000101, 1, 0);
    send(28'h0000202, 0, 0);
    send(28'h0000303, 0, 0);
    send(28'h0000404, 0, 1);
    idle(5);
    lat_on = 0;
    chk("drain1", q.size(), 0);
    send(28'h0000505, 0, 0);
    idle(3);

    // two lines, parity and mid-frame register change
    reg_h = 13'd2;
    reg_arr = BAYER_BGGR;
    send(28'h1111111, 1, 0);
    send(28'h1111112, 0, 1);
    reg_gain = {10'd7, 10'd8, 10'd9};
    reg_arr = BAYER_RGGB;
    send(28'h2222221, 0, 0);
    send(28'h2222222, 0, 1);
    send(28'h3333331, 1, 1);
    send(28'h3333332, 0, 1);
    idle(5);

    // stall for 4 cycles with output valid
    reg_h = 13'd1;
    send(28'h0A00001, 1, 0);
    send(28'h0A00002, 0, 0);
    send(28'h0A00003, 0, 0);
    out_ready = 0;
    in_if.i_VALID = 1;
    in_if.i_PIXELS = 28'h0A00004;
    for (int i = 0; i < 4; i++) begin
      step(g);
      chk("stall_acc", g, 0);
    end
    out_ready = 1;
    send(28'h0A00004, 0, 0);
    send(28'h0A00005, 0, 1);
    idle(5);
    chk("drain_stall", q.size(), 0);

    // SOF mid-frame restarts; SOF+EOL single-beat frame
    reg_h = 13'd2;
    send(28'h0B00001, 1, 0);
    send(28'h0B00002, 0, 0);
    send(28'h0B00003, 1, 1);
    send(28'h0B00004, 0, 1);
    reg_h = 13'd1;
    send(28'h0B00005, 1, 1);
    send(28'h0B00006, 0, 0);
    idle(4);
    err_clr = 1;
    idle(1);
    err_clr = 0;

    // height 0 ends frame on first EOL
    reg_h = 13'd0;
    send(28'h0C00001, 1, 0);
    send(28'h0C00002, 0, 1);
    send(28'h0C00003, 0, 1);
    idle(4);

    // error counter saturation, clear beats increment
    for (int i = 0; i < 258; i++) send(28'h0D00000 + 28'(i), 0, 0);
    idle(2);
    send(28'h0D00FFF, 0, 0);
    err_clr = 1;
    idle(1);
    err_clr = 0;
    idle(2);

    // random backpressure
    reg_h = 13'd3;
    rnd_rdy = 1;
    for (int f = 0; f < 2; f++) begin
      send(28'($urandom), 1, 0);
      for (int i = 0; i < 8; i++)
        send(28'($urandom), 0, (i % 3) == 2);
    end
    rnd_rdy = 0;
    out_ready = 1;
    idle(6);
    chk("drain_rnd", q.size(), 0);

    // reset with beats in flight
    reg_h = 13'd1;
    send(28'h0E00001, 1, 0);
    send(28'h0E00002, 0, 0);
    send(28'h0E00003, 0, 0);
    do_reset();
    idle(6);
    send(28'h0E00004, 1, 1);
    idle(5);
    chk("drain_rst", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/foo_ctrl.md
FOO_CTRL -- requirements
Module: foo_ctrl

Interface
REQ-001 Parameters SHALL be: p_k_bit, default 14, pixel width; p_ch_num_bit, default 2, pixels per beat; p_foo_gain_bit, default 10, gain width; p_line_cnt_bit, default 13, line counter width.
REQ-002 i_CLK  in  1  clock; i_RSTn  in  1  reset, asynchronous, active-low.
REQ-003 i_VALID  in  1  input beat valid; o_READY  out  1  input beat accepted when i_VALID & o_READY.
REQ-004 i_PIXELS  in  p_k_bit*p_ch_num_bit  pixel pair; i_SOF  in  1  first beat of frame; i_EOL  in  1  last beat of line.
REQ-005 i_REG_FOO_ARR_TYPE  in  2  Bayer type; i_REG_FOO_GAIN_VEC  in  3*p_foo_gain_bit  {B,G,R} gains; i_REG_FOO_HEIGHT  in  p_line_cnt_bit  lines per frame.
REQ-006 o_PIXELS  out  p_k_bit*p_ch_num_bit; o_ARR_TYPE  out  2; o_Y_LSB  out  1; o_COEFF_VEC  out  3*p_foo_gain_bit -- all feed the correction stage inputs.
REQ-007 o_ENA_VEC  out  2  correction pipeline enables.
REQ-008 o_OUT_VALID  out  1; i_OUT_READY  in  1; o_OUT_SOF  out  1; o_OUT_EOL  out  1 -- output stream qualifying the correction-stage output.
REQ-009 o_ERR  out  1  one-cycle protocol-error pulse; o_ERR_CNT  out  8  error count; i_ERR_CLR  in  1  clears o_ERR_CNT.

Function
REQ-010 stall SHALL equal o_OUT_VALID & ~i_OUT_READY; o_READY = ~stall; o_ENA_VEC = {~stall, ~stall}.
REQ-011 Stage-0 registers (o_PIXELS, o_Y_LSB, o_ARR_TYPE, o_COEFF_VEC, v0, sof0, eol0) SHALL load only when ~stall; v0 <= accepted beat that is part of a frame.
REQ-012 Valid/SOF/EOL SHALL shift through v0 -> v1 -> v2 on ~stall; o_OUT_VALID/SOF/EOL = v2 stage; beat accepted at cycle t appears at output at t+3 absent stall.
REQ-013 Bubbles (v=0) SHALL propagate; a stall SHALL freeze all stages including the correction stage via o_ENA_VEC.
REQ-014 FSM states IDLE, ACTIVE; reset to IDLE.
REQ-015 IDLE: accepted beat with i_SOF -> ACTIVE, line_cnt=0, parity=0, shadow ARR_TYPE and GAIN_VEC captured from registers; accepted non-SOF beat dropped (v0=0), o_ERR pulsed.
REQ-016 ACTIVE: accepted beat with i_EOL -> parity toggles, line_cnt+1; if line_cnt == i_REG_FOO_HEIGHT-1 (or HEIGHT==0) -> IDLE.
REQ-017 ACTIVE: accepted beat with i_SOF -> o_ERR pulse, frame restarts as in REQ-015 with that beat as its first beat.
REQ-018 Beat with both i_SOF and i_EOL SHALL start frame and end line 0 in the same cycle.
REQ-019 o_Y_LSB SHALL equal the parity of the beat's line; o_COEFF_VEC/o_ARR_TYPE SHALL use frame shadows, not live registers.
REQ-020 Register changes mid-frame SHALL not affect the current frame.

Reset
REQ-021 On i_RSTn low: all outputs 0 except o_READY=1; stage valids 0; shadows 0; FSM IDLE; o_ERR_CNT 0.
REQ-022 Reset mid-frame SHALL discard all in-flight beats; no output beat after release until a new SOF.

Configuration
REQ-023 With FOO_CTRL_ERR_CNT_EN defined: o_ERR_CNT increments on each o_ERR pulse, saturates at 255, clears on i_ERR_CLR (clear wins over simultaneous increment).
REQ-024 Without FOO_CTRL_ERR_CNT_EN: o_ERR_CNT tied to 0, counter logic absent; o_ERR unaffected.

Structure
REQ-025 Shared package foo_pkg SHALL hold FSM state encoding, Bayer type constants (RGGB=0, GRBG=1, GBRG=2, BGGR=3) and gain/width constants.
REQ-026 One sub-module foo_ctrl_fsm (frame/line tracking, shadows, error) is natural; the valid/stall pipeline stays in the top.

Verification
REQ-027 SOF + 3 beats, last with EOL, HEIGHT=1, i_OUT_READY=1 -> o_OUT_VALID high cycles t+3..t+6, o_OUT_SOF on first, o_OUT_EOL on last, FSM back to IDLE.
REQ-028 Two lines, HEIGHT=2 -> o_Y_LSB 0 for line 0 beats, 1 for line 1 beats.
REQ-029 i_OUT_READY low 4 cycles with o_OUT_VALID high -> o_READY=0, o_ENA_VEC=2'b00, outputs held; no beat lost or duplicated.
REQ-030 Non-SOF beat in IDLE -> o_ERR one pulse, no output beat; with macro o_ERR_CNT=1.
REQ-031 Change i_REG_FOO_GAIN_VEC mid-frame -> o_COEFF_VEC unchanged until next SOF.
REQ-032 Assert i_RSTn low with 3 beats in flight -> no o_OUT_VALID after release until new SOF + 3 cycles.
